// File: rtl/snake_master_state_machine.sv
// Snake game master controller: push-button conditioning plus the IDLE/PLAY/WIN/FAIL FSM.
// Optional macro COLLISION_FAIL_EN makes Collision a FAIL cause in PLAY.
module snake_master_state_machine #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEBOUNCE_WIDTH  = 20,
  parameter int WIN_SCORE       = 10
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] BUTTONS,
  input  logic [3:0] Score,
  input  logic       time_is_up,
  input  logic       Collision,
  output logic [1:0] Play_State,
  output logic [3:0] BTN_PULSE,
  output logic       GAME_CLEAR
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    FAIL = 2'b11
  } state_t;

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] WIN_SCORE_VEC = WIN_SCORE;
  localparam logic [3:0]  WIN_LEVEL     = WIN_SCORE_VEC[3:0];

  state_t                    state, state_next;
  logic                      clear, clear_next;
  logic [3:0]                sync1, sync2, deb, deb_prev, pulse;
  logic [DEBOUNCE_WIDTH-1:0] cnt [4];
  logic                      fail_cond;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      pulse    <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1    <= BUTTONS;
      sync2    <= sync1;
      deb_prev <= deb;
      pulse    <= deb & ~deb_prev;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef COLLISION_FAIL_EN
  assign fail_cond = time_is_up | Collision;
`else
  logic unused_collision;
  assign unused_collision = Collision;
  assign fail_cond        = time_is_up;
`endif

  always_comb begin
    state_next = state;
    clear_next = 1'b0;
    case (state)
      IDLE: if (|pulse) state_next = PLAY;
      PLAY: begin
        // WIN is checked first so it beats a simultaneous timeout or collision
        if (Score >= WIN_LEVEL) state_next = WIN;
        else if (fail_cond)     state_next = FAIL;
      end
      WIN, FAIL: begin
        if (|pulse) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_next;
      clear <= clear_next;
    end
  end

  assign Play_State = state;
  assign BTN_PULSE  = pulse;
  assign GAME_CLEAR = clear;

endmodule

// File: tb/tb_snake_master_state_machine.sv
// Scoreboard bench for snake_master_state_machine: directed scenarios then random stimulus.
module tb_snake_master_state_machine;

  localparam int D = 8;
  localparam logic [1:0] S_IDLE = 2'b00, S_PLAY = 2'b01, S_WIN = 2'b10, S_FAIL = 2'b11;
`ifdef COLLISION_FAIL_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] BUTTONS, Score;
  logic       time_is_up, Collision;
  logic [1:0] Play_State;
  logic [3:0] BTN_PULSE;
  logic       GAME_CLEAR;

  snake_master_state_machine #(
    .DEBOUNCE_CYCLES(D),
    .DEBOUNCE_WIDTH (4),
    .WIN_SCORE      (10)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .BUTTONS   (BUTTONS),
    .Score     (Score),
    .time_is_up(time_is_up),
    .Collision (Collision),
    .Play_State(Play_State),
    .BTN_PULSE (BTN_PULSE),
    .GAME_CLEAR(GAME_CLEAR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // expected {Play_State, BTN_PULSE, GAME_CLEAR} after each clock edge
  logic [6:0] exp_q [$];

  // reference model: stimulus history and accepted button levels
  logic [3:0] raw_hist [$];
  int         e;
  logic [3:0] deb_lvl, rose_prev, m_pulse;
  int         run_len [4];
  logic [1:0] m_state;
  logic       m_gc;

  logic [3:0] b_drv, sc_drv;
  logic       tu_drv, col_drv;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [6:0] x;
      x = exp_q.pop_front();
      check("play_state", {6'b0, Play_State}, {6'b0, x[6:5]});
      check("btn_pulse",  {4'b0, BTN_PULSE},  {4'b0, x[4:1]});
      check("game_clear", {7'b0, GAME_CLEAR}, {7'b0, x[0]});
    end
  end

  task automatic model_reset();
    e = 0;
    raw_hist.delete();
    deb_lvl   = '0;
    rose_prev = '0;
    m_pulse   = '0;
    m_state   = S_IDLE;
    m_gc      = 1'b0;
    for (int i = 0; i < 4; i++) run_len[i] = 0;
  endtask

  // Apply current drive values for one clock edge and predict the result.
  task automatic tick();
    logic [3:0] seen, rose_now;
    logic [1:0] ns;
    logic       gcn;
    BUTTONS    = b_drv;
    Score      = sc_drv;
    time_is_up = tu_drv;
    Collision  = col_drv;
    e++;
    raw_hist.push_back(b_drv);
    // a raw level reaches the debouncer two edges after it is sampled
    seen     = (e > 2) ? raw_hist[e-3] : 4'b0;
    rose_now = '0;
    for (int i = 0; i < 4; i++) begin
      if (seen[i] != deb_lvl[i]) run_len[i]++;
      else run_len[i] = 0;
      if (run_len[i] == D) begin
        deb_lvl[i]  = seen[i];
        run_len[i]  = 0;
        rose_now[i] = seen[i];
      end
    end
    ns  = m_state;
    gcn = 1'b0;
    if (m_state == S_IDLE && m_pulse != 0) ns = S_PLAY;
    else if (m_state == S_PLAY) begin
      if (sc_drv >= 4'd10) ns = S_WIN;
      else if (tu_drv || (COL_EN && col_drv)) ns = S_FAIL;
    end else if ((m_state == S_WIN || m_state == S_FAIL) && m_pulse != 0) begin
      ns  = S_IDLE;
      gcn = 1'b1;
    end
    m_state   = ns;
    m_gc      = gcn;
    m_pulse   = rose_prev;
    rose_prev = rose_now;
    @(posedge CLK);
    exp_q.push_back({m_state, m_pulse, m_gc});
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] bits);
    b_drv = bits;
    ticks(D + 6);
    b_drv = '0;
    ticks(D + 6);
  endtask

  task automatic do_reset();
    RESET_N    = 1'b0;
    b_drv      = '0;
    BUTTONS    = '0;
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge CLK);
    #2;
    check("rst_state", {6'b0, Play_State}, 8'h00);
    check("rst_pulse", {4'b0, BTN_PULSE},  8'h00);
    check("rst_clear", {7'b0, GAME_CLEAR}, 8'h00);
    RESET_N = 1'b1;
  endtask

  initial begin
    b_drv = '0; sc_drv = '0; tu_drv = 1'b0; col_drv = 1'b0;
    Score = '0; time_is_up = 1'b0; Collision = 1'b0;
    #1;
    do_reset();

    // bouncing BTNU never settles, then a clean hold gives one press
    for (int c = 0; c < 30; c++) begin
      b_drv = ((c / 3) % 2 == 0) ? 4'b1000 : 4'b0000;
      tick();
    end
    b_drv = 4'b1000;
    ticks(20);
    b_drv = '0;
    ticks(D + 6);

    // score ramps to the win threshold, then BTNL returns to IDLE
    sc_drv = 4'd0; ticks(3);
    sc_drv = 4'd9; ticks(3);
    sc_drv = 4'd10; ticks(3);
    press(4'b0010);
    sc_drv = 4'd0;

    // timeout, held through FAIL, BTNR clears
    press(4'b0100);
    tu_drv = 1'b1;
    ticks(10);
    press(4'b0001);
    tu_drv = 1'b0;

    // win beats timeout and collision in the same cycle
    press(4'b1100);
    sc_drv = 4'd10; tu_drv = 1'b1; col_drv = 1'b1;
    tick();
    sc_drv = 4'd0; tu_drv = 1'b0; col_drv = 1'b0;
    ticks(3);
    press(4'b1111);

    // single collision pulse in PLAY
    press(4'b0001);
    col_drv = 1'b1; tick();
    col_drv = 1'b0; ticks(4);

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) b_drv[i] = ~b_drv[i];
      if ($urandom_range(0, 19) == 0) sc_drv = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) sc_drv = 4'd0;
      if ($urandom_range(0, 39) == 0) tu_drv = ~tu_drv;
      col_drv = ($urandom_range(0, 29) == 0);
      tick();
    end

    // get into PLAY, then drop reset between edges
    b_drv = '0; sc_drv = '0; tu_drv = 1'b0; col_drv = 1'b0;
    ticks(D + 6);
    for (int k = 0; k < 4 && m_state != S_PLAY; k++) press(4'b0100);
    check("pre_reset_play", {6'b0, Play_State}, 8'h01);
    b_drv = 4'b0010;
    ticks(D + 4);
    #2;
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    check("async_state", {6'b0, Play_State}, 8'h00);
    check("async_pulse", {4'b0, BTN_PULSE},  8'h00);
    check("async_clear", {7'b0, GAME_CLEAR}, 8'h00);
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) b_drv[i] = ~b_drv[i];
      tu_drv = ($urandom_range(0, 49) == 0);
      tick();
    end

    @(negedge CLK);
    @(negedge CLK);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
